// File: rtl/flag_seq_ctrl.sv
// Flag-register update sequencer: arbitrates per-instruction flag updates against
// SWI / RFE / HALT events and keeps a bounded stack of flag snapshots for nested entry.
module flag_seq_ctrl #(
  parameter int SAVE_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          op_valid,
  input  logic [2:0]                    op_update,
  input  logic                          swi_req,
  input  logic                          rfe_req,
  input  logic                          halt_req,
  input  logic [4:0]                    flags,
  output logic [2:0]                    update_mode,
  output logic                          stall,
  output logic                          exc_ack,
  output logic [4:0]                    saved_flags,
  output logic [$clog2(SAVE_DEPTH):0]   depth,
  output logic                          fault,
  output logic                          halted
);

  localparam int DW = $clog2(SAVE_DEPTH) + 1;
  localparam int IW = $clog2(SAVE_DEPTH);

  localparam logic [2:0] UM_HOLD    = 3'd0;
  localparam logic [2:0] UM_TOGGLE  = 3'd5;
  localparam logic [2:0] UM_SET_ALL = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE, S_SWI_SAVE, S_SWI_TOGGLE, S_RFE_POP, S_HALT_SET, S_HALTED
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      update_mode_q, update_mode_d;
  logic            exc_ack_q, exc_ack_d;
  logic            fault_q, fault_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic [4:0]      stack_q [SAVE_DEPTH];

  logic            push, pop;
  logic            stack_full, stack_empty;
  logic [IW-1:0]   push_idx, top_idx;
  logic [4:0]      top_flags;
  logic            op_is_update;

  assign stack_full   = (depth_q == DW'(SAVE_DEPTH));
  assign stack_empty  = (depth_q == '0);
  assign push_idx     = IW'(depth_q);
  assign top_idx      = IW'(depth_q - 1'b1);
  assign top_flags    = stack_empty ? 5'd0 : stack_q[top_idx];
  assign op_is_update = (op_update >= 3'd1) && (op_update <= 3'd4);

  // State register plus the registered side-effects of each transition.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      update_mode_q <= UM_HOLD;
      exc_ack_q     <= 1'b0;
      fault_q       <= 1'b0;
      depth_q       <= '0;
      for (int i = 0; i < SAVE_DEPTH; i++) stack_q[i] <= 5'd0;
    end else begin
      state_q       <= state_d;
      update_mode_q <= update_mode_d;
      exc_ack_q     <= exc_ack_d;
      fault_q       <= fault_d;
      depth_q       <= depth_d;
      if (push) stack_q[push_idx] <= flags;
      else if (pop) stack_q[top_idx] <= 5'd0;
    end
  end

  // update_mode is registered on the transition so the flag register sees it
  // at the negedge of the first cycle spent in the destination state.
  always_comb begin
    state_d       = state_q;
    update_mode_d = UM_HOLD;
    exc_ack_d     = 1'b0;
    fault_d       = fault_q;
    push          = 1'b0;
    pop           = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (halt_req) begin
          state_d       = S_HALT_SET;
          update_mode_d = UM_SET_ALL;
        end else if (swi_req) begin
          if (stack_full) begin
            fault_d = 1'b1;
          end else begin
            state_d       = S_SWI_SAVE;
            push          = 1'b1;
            // Only the outermost entry (M clear) flips into supervisor mode.
            update_mode_d = flags[0] ? UM_HOLD : UM_TOGGLE;
          end
        end else if (rfe_req) begin
          if (stack_empty) begin
            fault_d = 1'b1;
          end else begin
            state_d       = S_RFE_POP;
            pop           = 1'b1;
            update_mode_d = (!top_flags[0] && flags[0]) ? UM_TOGGLE : UM_HOLD;
          end
        end else if (op_valid && op_is_update) begin
          update_mode_d = op_update;
        end
      end
      S_SWI_SAVE: begin
        state_d   = S_SWI_TOGGLE;
        exc_ack_d = 1'b1;
      end
      S_SWI_TOGGLE: state_d = S_IDLE;
      S_RFE_POP: begin
        state_d   = S_IDLE;
        exc_ack_d = 1'b1;
      end
      S_HALT_SET: state_d = S_HALTED;
      S_HALTED:   state_d = S_HALTED;
      default:    state_d = S_IDLE;
    endcase

    depth_d = depth_q;
    if (push)     depth_d = depth_q + 1'b1;
    else if (pop) depth_d = depth_q - 1'b1;
  end

  always_comb begin
    stall  = 1'b1;
    halted = 1'b0;
    unique case (state_q)
      S_IDLE:   stall  = halt_req | swi_req | rfe_req;
      S_HALTED: halted = 1'b1;
      default:  stall  = 1'b1;
    endcase
  end

  assign update_mode = update_mode_q;
  assign exc_ack     = exc_ack_q;
  assign fault       = fault_q;
  assign depth       = depth_q;
  assign saved_flags = top_flags;

endmodule

// File: doc/flag_seq_ctrl.md
# flag_seq_ctrl

Sequencer for the CPU's 5-bit flag/special register {N,Z,C,V,M}. It sits between instruction decode and the flag register and is the only driver of its 3-bit update_mode select. It arbitrates between per-instruction flag updates and control events (SWI, return-from-exception, HALT), and keeps a bounded stack of flag snapshots for nested supervisor entry. The flag register samples update_mode on the falling clock edge; this block runs on the rising edge.

## Interface
- SAVE_DEPTH, 4: flag-snapshot stack entries (2..8)
- clock  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- op_valid  in  1  decode presents a flag-updating instruction this cycle
- op_update  in  3  requested mode: 1 shifter NZC, 2 ALU NZCV, 3 ALU NZ, 4 ALU V; 0/5/6/7 treated as no update
- swi_req  in  1  software interrupt request (level, sampled in IDLE)
- rfe_req  in  1  return-from-exception request
- halt_req  in  1  halt request
- flags  in  5  current flag register {N,Z,C,V,M}
- update_mode  out  3  registered select to flag register (0 hold, 1–4 as above, 5 toggle M, 6 set all)
- stall  out  1  combinational; decode must hold its instruction
- exc_ack  out  1  registered one-cycle pulse on SWI/RFE completion
- saved_flags  out  5  top-of-stack snapshot (0 when empty)
- depth  out  $clog2(SAVE_DEPTH)+1  stack occupancy
- fault  out  1  sticky: stack overflow or underflow
- halted  out  1  high in HALTED

## Operation
- States: IDLE, SWI_SAVE, SWI_TOGGLE, RFE_POP, HALT_SET, HALTED.
- IDLE priority: halt_req > swi_req > rfe_req > op_valid. Only the winner is serviced.
- stall = (state != IDLE) | (state == IDLE & (halt_req | swi_req | rfe_req)). A concurrent op_valid is not consumed; decode re-presents it.
- IDLE, op_valid with op_update in 1..4, no event: update_mode <= op_update for one cycle. Otherwise update_mode <= 0.
- SWI, stack not full: go to SWI_SAVE, push flags into the stack, depth+1. In SWI_SAVE, if the pushed M == 0, update_mode <= 5; else update_mode <= 0. Nested SWI does not toggle. Go to SWI_TOGGLE, which sets exc_ack <= 1 and update_mode <= 0, then returns to IDLE.
- SWI, stack full (depth == SAVE_DEPTH): fault <= 1, no push, no toggle, no exc_ack; stay in IDLE.
- RFE, depth > 0: go to RFE_POP, depth-1. Pop and compare. If popped M == 0 and flags M == 1, update_mode <= 5. exc_ack <= 1. Return to IDLE. N/Z/C/V are not restored; the popped entry is software-visible only while on top.
- RFE, depth == 0: fault <= 1; stay in IDLE; update_mode 0.
- HALT: HALT_SET drives update_mode <= 6 for one cycle, then HALTED. HALTED holds update_mode 0, stall 1, halted 1, and ignores all requests until reset.
- saved_flags = stack[depth-1], combinational from stack; 0 when depth == 0.
- fault clears only on reset.

## Timing
- update_mode changes on posedge N and is sampled by the flag register at the following negedge (half-cycle latency).
- Instruction update: op presented in cycle N; flags visible after negedge of N+1.
- SWI: request in cycle N; stall high in N..N+2. Toggle applied at negedge of N+1. exc_ack high in N+2. IDLE in N+3.
- RFE: request in N; stall N..N+1; toggle at negedge of N+1; exc_ack in N+2.
- Every non-zero update_mode lasts exactly one cycle, except in HALTED where it is 0.
- Reset (any state, including mid-SWI) wins. Next cycle: state IDLE, update_mode 0, stall 0, exc_ack 0, depth 0, stack cleared, saved_flags 0, fault 0, halted 0. A snapshot pushed before reset is discarded.

## Test plan
- After reset, op_valid=1 with op_update=2 for one cycle -> update_mode=2 in next cycle only, stall=0.
- flags=5'b10100, swi_req one cycle -> stall 3 cycles, update_mode=5 once, exc_ack pulse, depth=1, saved_flags=5'b10100.
- Nested: SWI with M=0 then SWI with M=1 -> second produces no toggle, depth=2. Two RFEs -> first no toggle (popped M=1); second toggles (popped M=0, current M=1); depth=0.
- SAVE_DEPTH+1 SWIs -> last sets fault=1, depth stays 4, no exc_ack. RFE at depth 0 -> fault=1, update_mode=0.
- halt_req with swi_req and op_valid together -> update_mode=6 once, halted=1, stall=1. Later swi_req has no effect. reset -> all outputs 0.
- Reset asserted in SWI_SAVE cycle -> next cycle IDLE, depth=0, no exc_ack, update_mode=0.
